// File: rtl/snake_mem_pkg.sv
// Shared widths and requester encoding for the snake board/frame memory arbiter.
package snake_mem_pkg;

    localparam int unsigned MEM_AW  = 22;
    localparam int unsigned MEM_DW  = 16;
    localparam int unsigned MEM_BEW = 2;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_VID,
        SRC_GM
    } req_src_e;

endpackage

// File: rtl/snake_mem_rdtag_pipe.sv
// Read-return tag pipe: tracks which master owns each in-flight read and steers
// memory readdata to that master, holding the last returned word per port.
module snake_mem_rdtag_pipe
    import snake_mem_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vid_rd_i,
    input  logic              gm_rd_i,
    input  logic [MEM_DW-1:0] mem_rdata_i,
    output logic              vid_rvalid_o,
    output logic [MEM_DW-1:0] vid_rdata_o,
    output logic              gm_rvalid_o,
    output logic [MEM_DW-1:0] gm_rdata_o
);

    logic [RD_LAT-1:0] vid_tag_q;
    logic [RD_LAT-1:0] gm_tag_q;
    logic [MEM_DW-1:0] vid_hold_q;
    logic [MEM_DW-1:0] gm_hold_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vid_tag_q <= '0;
            gm_tag_q  <= '0;
        end else begin
            vid_tag_q[0] <= vid_rd_i;
            gm_tag_q[0]  <= gm_rd_i;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vid_tag_q[i] <= vid_tag_q[i-1];
                gm_tag_q[i]  <= gm_tag_q[i-1];
            end
        end
    end

    assign vid_rvalid_o = vid_tag_q[RD_LAT-1];
    assign gm_rvalid_o  = gm_tag_q[RD_LAT-1];

    // Data is passed through in the return cycle so rvalid and rdata line up
    // with the memory's own latency; the hold registers cover idle cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vid_hold_q <= '0;
            gm_hold_q  <= '0;
        end else begin
            if (vid_rvalid_o) vid_hold_q <= mem_rdata_i;
            if (gm_rvalid_o)  gm_hold_q  <= mem_rdata_i;
        end
    end

    assign vid_rdata_o = vid_rvalid_o ? mem_rdata_i : vid_hold_q;
    assign gm_rdata_o  = gm_rvalid_o  ? mem_rdata_i : gm_hold_q;

endmodule

// File: rtl/snake_mem_arbiter.sv
// Video-priority arbiter with streak guard for the snake board/frame memory.
// Optional grant statistics outputs enabled by defining SNAKE_MEM_ARB_STATS_EN.
module snake_mem_arbiter
    import snake_mem_pkg::*;
#(
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned MAX_VID_STREAK = 8
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               vid_req,
    input  logic [MEM_AW-1:0]  vid_addr,
    output logic               vid_gnt,
    output logic               vid_rvalid,
    output logic [MEM_DW-1:0]  vid_rdata,
    input  logic               gm_req,
    input  logic               gm_we,
    input  logic [MEM_AW-1:0]  gm_addr,
    input  logic [MEM_DW-1:0]  gm_wdata,
    input  logic [MEM_BEW-1:0] gm_be,
    output logic               gm_gnt,
    output logic               gm_rvalid,
    output logic [MEM_DW-1:0]  gm_rdata,
    output logic [MEM_AW-1:0]  mem_address,
    output logic               mem_chipselect,
    output logic               mem_write,
    output logic [MEM_DW-1:0]  mem_writedata,
    output logic [MEM_BEW-1:0] mem_byteenable,
    output logic               mem_clken,
    input  logic [MEM_DW-1:0]  mem_readdata
`ifdef SNAKE_MEM_ARB_STATS_EN
    ,
    output logic [15:0]        stat_vid_cnt,
    output logic [15:0]        stat_gm_cnt,
    output logic [15:0]        stat_starve_cnt
`endif
);

    localparam logic [7:0] STREAK_MAX = 8'(MAX_VID_STREAK);

    req_src_e   src;
    logic       guard;
    logic [7:0] streak_q, streak_d;

    always_comb begin
        src   = SRC_NONE;
        guard = gm_req && (streak_q == STREAK_MAX);
        if (!reset_reset) begin
            if (vid_req && !guard) src = SRC_VID;
            else if (gm_req)       src = SRC_GM;
        end
    end

    always_comb begin
        vid_gnt        = 1'b0;
        gm_gnt         = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        case (src)
            SRC_VID: begin
                vid_gnt        = 1'b1;
                mem_chipselect = 1'b1;
                mem_address    = vid_addr;
                mem_byteenable = '1;
            end
            SRC_GM: begin
                gm_gnt         = 1'b1;
                mem_chipselect = 1'b1;
                mem_write      = gm_we;
                mem_address    = gm_addr;
                mem_writedata  = gm_wdata;
                mem_byteenable = gm_we ? gm_be : '1;
            end
            default: ;
        endcase
    end

    assign mem_clken = 1'b1;

    always_comb begin
        streak_d = streak_q;
        if (!gm_req || src == SRC_GM)
            streak_d = '0;
        else if (src == SRC_VID && streak_q != STREAK_MAX)
            streak_d = streak_q + 8'd1;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) streak_q <= '0;
        else             streak_q <= streak_d;
    end

    snake_mem_rdtag_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rdtag (
        .clk_i        (clk_clk),
        .rst_i        (reset_reset),
        .vid_rd_i     (vid_gnt),
        .gm_rd_i      (gm_gnt && !gm_we),
        .mem_rdata_i  (mem_readdata),
        .vid_rvalid_o (vid_rvalid),
        .vid_rdata_o  (vid_rdata),
        .gm_rvalid_o  (gm_rvalid),
        .gm_rdata_o   (gm_rdata)
    );

`ifdef SNAKE_MEM_ARB_STATS_EN
    logic [15:0] stat_vid_q, stat_gm_q, stat_starve_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            stat_vid_q    <= '0;
            stat_gm_q     <= '0;
            stat_starve_q <= '0;
        end else begin
            if (src == SRC_VID) stat_vid_q <= stat_vid_q + 16'd1;
            if (src == SRC_GM)  stat_gm_q  <= stat_gm_q + 16'd1;
            if (src == SRC_GM && vid_req) stat_starve_q <= stat_starve_q + 16'd1;
        end
    end

    assign stat_vid_cnt    = stat_vid_q;
    assign stat_gm_cnt     = stat_gm_q;
    assign stat_starve_cnt = stat_starve_q;
`endif

endmodule

// File: tb/tb_snake_mem_arbiter.sv
// Directed self-checking bench for snake_mem_arbiter with a small memory model.
module tb_snake_mem_arbiter;

    localparam int unsigned RD_LAT = 1;
    localparam int unsigned MAXS   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vid_req = 1'b0;
    logic [21:0] vid_addr = '0;
    logic        vid_gnt, vid_rvalid;
    logic [15:0] vid_rdata;
    logic        gm_req = 1'b0, gm_we = 1'b0;
    logic [21:0] gm_addr = '0;
    logic [15:0] gm_wdata = '0;
    logic [1:0]  gm_be = '0;
    logic        gm_gnt, gm_rvalid;
    logic [15:0] gm_rdata;
    logic [21:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [15:0] mem_writedata, mem_readdata;
    logic [1:0]  mem_byteenable;
`ifdef SNAKE_MEM_ARB_STATS_EN
    logic [15:0] stat_vid_cnt, stat_gm_cnt, stat_starve_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    snake_mem_arbiter #(
        .RD_LAT(RD_LAT),
        .MAX_VID_STREAK(MAXS)
    ) dut (
        .clk_clk(clk), .reset_reset(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata),
        .gm_be(gm_be), .gm_gnt(gm_gnt), .gm_rvalid(gm_rvalid), .gm_rdata(gm_rdata),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
`ifdef SNAKE_MEM_ARB_STATS_EN
        ,
        .stat_vid_cnt(stat_vid_cnt), .stat_gm_cnt(stat_gm_cnt),
        .stat_starve_cnt(stat_starve_cnt)
`endif
    );

    // Memory model: synchronous write with byte enables, RD_LAT-cycle read.
    logic [15:0] mem_model [0:1023];
    logic [15:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_chipselect && mem_write) begin
            if (mem_byteenable[0]) mem_model[mem_address[9:0]][7:0]  <= mem_writedata[7:0];
            if (mem_byteenable[1]) mem_model[mem_address[9:0]][15:8] <= mem_writedata[15:8];
        end
        rd_pipe[0] <= (mem_chipselect && !mem_write) ? mem_model[mem_address[9:0]] : 16'h0000;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_readdata = rd_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic gm_write(input logic [21:0] a, input logic [15:0] d, input logic [1:0] be);
        gm_req = 1'b1; gm_we = 1'b1; gm_addr = a; gm_wdata = d; gm_be = be;
        @(negedge clk);
        chk("gm_write_gnt", {31'd0, gm_gnt}, 32'd1);
        next_cyc();
        gm_req = 1'b0; gm_we = 1'b0; gm_wdata = '0; gm_be = '0;
    endtask

    task automatic gm_read_check(input string name, input logic [21:0] a, input logic [15:0] exp);
        gm_req = 1'b1; gm_we = 1'b0; gm_addr = a;
        @(negedge clk);
        chk({name, "_gnt"}, {31'd0, gm_gnt}, 32'd1);
        next_cyc();
        gm_req = 1'b0;
        for (int i = 1; i < RD_LAT; i++) begin
            @(negedge clk);
            chk({name, "_early_rvalid"}, {31'd0, gm_rvalid}, 32'd0);
            next_cyc();
        end
        @(negedge clk);
        chk({name, "_rvalid"}, {31'd0, gm_rvalid}, 32'd1);
        chk({name, "_rdata"}, {16'd0, gm_rdata}, {16'd0, exp});
        next_cyc();
        @(negedge clk);
        chk({name, "_rvalid_drop"}, {31'd0, gm_rvalid}, 32'd0);
        chk({name, "_rdata_hold"}, {16'd0, gm_rdata}, {16'd0, exp});
        next_cyc();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_gnts"},    {30'd0, vid_gnt, gm_gnt}, 32'd0);
        chk({name, "_rvalids"}, {30'd0, vid_rvalid, gm_rvalid}, 32'd0);
        chk({name, "_rdata"},   {vid_rdata, gm_rdata}, 32'd0);
        chk({name, "_mem_ctl"}, {29'd0, mem_chipselect, mem_write, mem_clken}, 32'd1);
        chk({name, "_mem_bus"}, {8'd0, mem_address, 2'd0}, 32'd0);
        chk({name, "_mem_wd"},  {14'd0, mem_writedata, mem_byteenable}, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic        vreq;
        logic [21:0] vaddr;
        logic        greq;
        logic        gwe;
        logic [21:0] gaddr;
        logic [15:0] gwd;
        logic [1:0]  gbe;
        logic        e_vg;
        logic        e_gg;
        logic        e_cs;
        logic        e_wr;
        logic [21:0] e_addr;
        logic [15:0] e_wd;
        logic [1:0]  e_be;
    } vec_t;

    vec_t vecs [7];

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 16'h0000;
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 16'h0000;

        vecs[0] = '{"v_idle",    0, 22'h000000, 0, 0, 22'h000000, 16'h0000, 2'b00, 0, 0, 0, 0, 22'h000000, 16'h0000, 2'b00};
        vecs[1] = '{"v_vid_rd",  1, 22'h3ABCDE, 0, 0, 22'h000000, 16'h0000, 2'b00, 1, 0, 1, 0, 22'h3ABCDE, 16'h0000, 2'b11};
        vecs[2] = '{"v_gm_rd",   0, 22'h000000, 1, 0, 22'h000200, 16'h0000, 2'b01, 0, 1, 1, 0, 22'h000200, 16'h0000, 2'b11};
        vecs[3] = '{"v_gm_wr",   0, 22'h000000, 1, 1, 22'h000201, 16'h1234, 2'b10, 0, 1, 1, 1, 22'h000201, 16'h1234, 2'b10};
        vecs[4] = '{"v_both",    1, 22'h000123, 1, 1, 22'h000202, 16'h5678, 2'b11, 1, 0, 1, 0, 22'h000123, 16'h0000, 2'b11};
        vecs[5] = '{"v_gm_be0",  0, 22'h000000, 1, 1, 22'h000203, 16'hCAFE, 2'b00, 0, 1, 1, 1, 22'h000203, 16'hCAFE, 2'b00};
        vecs[6] = '{"v_vid_max", 1, 22'h3FFFFF, 0, 0, 22'h000000, 16'h0000, 2'b00, 1, 0, 1, 0, 22'h3FFFFF, 16'h0000, 2'b11};

        #1 rst = 1'b1;
        #2;
        chk_reset_outputs("reset");
        next_cyc();
        next_cyc();
        chk_reset_outputs("reset_held");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            vid_req = vecs[i].vreq; vid_addr = vecs[i].vaddr;
            gm_req = vecs[i].greq; gm_we = vecs[i].gwe; gm_addr = vecs[i].gaddr;
            gm_wdata = vecs[i].gwd; gm_be = vecs[i].gbe;
            @(negedge clk);
            chk({vecs[i].name, "_gnt"}, {30'd0, vid_gnt, gm_gnt}, {30'd0, vecs[i].e_vg, vecs[i].e_gg});
            chk({vecs[i].name, "_ctl"}, {30'd0, mem_chipselect, mem_write}, {30'd0, vecs[i].e_cs, vecs[i].e_wr});
            chk({vecs[i].name, "_addr"}, {10'd0, mem_address}, {10'd0, vecs[i].e_addr});
            chk({vecs[i].name, "_wd_be"}, {14'd0, mem_writedata, mem_byteenable},
                {14'd0, vecs[i].e_wd, vecs[i].e_be});
            next_cyc();
            vid_req = 1'b0; gm_req = 1'b0; gm_we = 1'b0; gm_wdata = '0; gm_be = '0;
            next_cyc();
        end

        gm_write(22'h000010, 16'hBEEF, 2'b11);
        gm_read_check("solo_rd", 22'h000010, 16'hBEEF);

        gm_write(22'h000010, 16'h1234, 2'b11);
        gm_write(22'h000010, 16'hAB00, 2'b10);
        gm_read_check("be_rd", 22'h000010, 16'hAB34);

        // Reset lands while a game read is in flight.
        gm_req = 1'b1; gm_we = 1'b0; gm_addr = 22'h000100;
        @(negedge clk);
        chk("midrd_gnt", {31'd0, gm_gnt}, 32'd1);
        next_cyc();
        rst = 1'b1; gm_req = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrd_reset");
        for (int i = 0; i < 2; i++) begin
            next_cyc();
            @(negedge clk);
            chk("midrd_rvalid_in_rst", {30'd0, vid_rvalid, gm_rvalid}, 32'd0);
        end
        next_cyc();
        rst = 1'b0;
        for (int i = 0; i < RD_LAT + 1; i++) begin
            @(negedge clk);
            chk("midrd_rvalid_after", {30'd0, vid_rvalid, gm_rvalid}, 32'd0);
            next_cyc();
        end

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", {26'd0, mem_chipselect, mem_write, vid_gnt, gm_gnt, vid_rvalid, gm_rvalid}, 32'd0);
            next_cyc();
        end

        // Both masters hold requests: 8 video grants, then one forced game grant.
        vid_req = 1'b1; vid_addr = 22'h000001;
        gm_req = 1'b1; gm_we = 1'b0; gm_addr = 22'h000002;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            chk("contend_gnt", {30'd0, vid_gnt, gm_gnt},
                (i % 9 == 8) ? 32'd1 : 32'd2);
            next_cyc();
        end
`ifdef SNAKE_MEM_ARB_STATS_EN
        chk("stat_vid",    {16'd0, stat_vid_cnt},    32'd24);
        chk("stat_gm",     {16'd0, stat_gm_cnt},     32'd3);
        chk("stat_starve", {16'd0, stat_starve_cnt}, 32'd3);
`endif
        vid_req = 1'b0; gm_req = 1'b0;
        for (int i = 0; i < RD_LAT + 1; i++) next_cyc();

        for (int a = 0; a < 16; a++) gm_write(22'(a), 16'(a), 2'b11);

        for (int t = 0; t < 16 + RD_LAT; t++) begin
            vid_req = 1'b0; gm_req = 1'b0; gm_we = 1'b0;
            if (t < 16) begin
                if (t % 2 == 0) begin vid_req = 1'b1; vid_addr = 22'(t); end
                else begin gm_req = 1'b1; gm_addr = 22'(t); end
            end
            @(negedge clk);
            if (t < 16)
                chk("order_gnt", {30'd0, vid_gnt, gm_gnt}, (t % 2 == 0) ? 32'd2 : 32'd1);
            if (t >= RD_LAT) begin
                chk("order_rvalid", {30'd0, vid_rvalid, gm_rvalid},
                    ((t - RD_LAT) % 2 == 0) ? 32'd2 : 32'd1);
                chk("order_rdata",
                    {16'd0, ((t - RD_LAT) % 2 == 0) ? vid_rdata : gm_rdata}, 32'(t - RD_LAT));
            end
            next_cyc();
        end
        vid_req = 1'b0; gm_req = 1'b0;
        @(negedge clk);
        chk("order_drain", {30'd0, vid_rvalid, gm_rvalid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
